image_streamer: RTL and testbench

Frame-read transmitter that fetches a ROW_SIZE x COLUMN_SIZE image from a synchronous-read frame memory and emits it as a raster-order pixel stream (data_out / data_out_valid) that connects directly to the data_in / data_in_valid inputs of Image_Buffer. A start/done handshake controls it, and an optional pause input inserts bubbles into the stream. The streamer is the source end of the pixel-stream interface that Image_Buffer receives.

---
 rtl/cnn_stream_pkg.sv | 21 ++
 rtl/raster_counter.sv | 63 ++++++
 rtl/image_streamer.sv | 114 +++++++++++
 tb/tb_image_streamer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cnn_stream_pkg.sv
// Shared definitions for pixel-stream sources and sinks: stream FSM states,
// default frame geometry and counter width helper.
package cnn_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } stream_state_e;

    localparam int unsigned ROW_SIZE_DEF    = 5;
    localparam int unsigned COLUMN_SIZE_DEF = 5;
    localparam int unsigned N               = ROW_SIZE_DEF * COLUMN_SIZE_DEF;

    // Counter width for values 0..n-1; at least one bit so 1-wide frames still elaborate.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order col/row/index counters with enable, synchronous clear and
// end-of-row / end-of-frame wrap flags.
module raster_counter
    import cnn_stream_pkg::*;
#(
    parameter int unsigned COLS = 5,
    parameter int unsigned ROWS = 5
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 clear_i,
    input  logic                                 en_i,
    output logic [cnt_width(COLS*ROWS)-1:0]      idx_o,
    output logic                                 col_last_o,
    output logic                                 frame_last_o
);

    localparam int unsigned CW = cnt_width(COLS);
    localparam int unsigned RW = cnt_width(ROWS);
    localparam int unsigned IW = cnt_width(COLS * ROWS);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          row_last;

    assign col_last_o   = (col_q == CW'(COLS - 1));
    assign row_last     = (row_q == RW'(ROWS - 1));
    assign frame_last_o = col_last_o && row_last;
    assign idx_o        = idx_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        idx_d = idx_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
            idx_d = '0;
        end else if (en_i) begin
            if (col_last_o) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            idx_d = frame_last_o ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
            idx_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/image_streamer.sv
// Frame-read transmitter: fetches a ROW_SIZE x COLUMN_SIZE frame from a
// synchronous-read memory and emits it as a raster-order pixel stream.
module image_streamer
    import cnn_stream_pkg::*;
#(
    parameter int unsigned DATA_SIZE   = 8,
    parameter int unsigned ROW_SIZE    = ROW_SIZE_DEF,
    parameter int unsigned COLUMN_SIZE = COLUMN_SIZE_DEF,
    parameter int unsigned ADDR_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  pause,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_SIZE-1:0]  mem_rd_data,
    output logic [DATA_SIZE-1:0]  data_out,
    output logic                  data_out_valid,
    output logic                  row_last,
    output logic                  frame_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned IW = cnt_width(ROW_SIZE * COLUMN_SIZE);

    stream_state_e         state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  vld_q;
    logic                  rl_q;
    logic                  fl_q;
    logic [DATA_SIZE-1:0]  hold_q;

    logic [IW-1:0]         idx;
    logic                  col_last;
    logic                  pix_last;
    logic                  rd_en;
    logic                  accept;

    assign accept = (state_q == ST_IDLE) && start;
    assign rd_en  = (state_q == ST_READ) && !pause;

    raster_counter #(
        .COLS (ROW_SIZE),
        .ROWS (COLUMN_SIZE)
    ) u_raster (
        .clk_i        (clock),
        .rst_i        (reset),
        .clear_i      (accept),
        .en_i         (rd_en),
        .idx_o        (idx),
        .col_last_o   (col_last),
        .frame_last_o (pix_last)
    );

    // The read strobe follows pause in the same cycle so a paused cycle issues nothing.
    assign mem_rd_en      = rd_en;
    assign mem_addr       = base_q + ADDR_WIDTH'(idx);
    assign data_out       = vld_q ? mem_rd_data : hold_q;
    assign data_out_valid = vld_q;
    assign row_last       = rl_q;
    assign frame_last     = fl_q;
    assign busy           = busy_q;
    assign done           = done_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            rl_q    <= 1'b0;
            fl_q    <= 1'b0;
            hold_q  <= '0;
        end else begin
            vld_q  <= rd_en;
            rl_q   <= rd_en && col_last;
            fl_q   <= rd_en && pix_last;
            done_q <= 1'b0;
            if (vld_q) begin
                hold_q <= mem_rd_data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        busy_q  <= 1'b1;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (rd_en && pix_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_streamer.sv
// Scoreboard bench for image_streamer: stimulus pushes expected pixels with
// their expected output cycle; a negedge monitor pops and compares.
module tb_image_streamer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [15:0] base_addr = '0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rd_data = '0;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic        row_last;
    logic        frame_last;
    logic        busy;
    logic        done;

    image_streamer #(
        .DATA_SIZE   (8),
        .ROW_SIZE    (5),
        .COLUMN_SIZE (5),
        .ADDR_WIDTH  (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .pause          (pause),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_rd_data    (mem_rd_data),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .row_last       (row_last),
        .frame_last     (frame_last),
        .busy           (busy),
        .done           (done)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Frame memory: each location holds the low byte of its address.
    always @(posedge clock) if (mem_rd_en) mem_rd_data <= mem_addr[7:0];

    typedef struct {
        logic [7:0]  d;
        logic        rl;
        logic        fl;
        int unsigned cyc;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int passes = 0;
    int done_cnt = 0;
    int unsigned done_cyc = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (data_out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_pixel: got data 0x%0h expected no pixel (cycle %0d)", data_out, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pixel_data", data_out, e.d);
                    check("pixel_row_last", row_last, e.rl);
                    check("pixel_frame_last", frame_last, e.fl);
                    check("pixel_cycle", cyc, e.cyc);
                end
            end else if (busy) begin
                check("bubble_tags", {row_last, frame_last}, 0);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_frame(input logic [15:0] base, input int unsigned k,
                              input int ps, input int plen);
        for (int i = 0; i < 25; i++) begin
            exp_t e;
            logic [15:0] a;
            int unsigned issue;
            a     = base + 16'(i);
            issue = (plen == 0 || i < ps - 1) ? k + 1 + i : k + 1 + i + plen;
            e.d   = a[7:0];
            e.rl  = (i % 5 == 4);
            e.fl  = (i == 24);
            e.cyc = issue + 1;
            exp_q.push_back(e);
        end
    endtask

    task automatic run_frame(input logic [15:0] base, input int ps, input int plen,
                             input bit repulse);
        int unsigned k;
        int d0;
        @(posedge clock); #1;
        d0 = done_cnt;
        base_addr = base;
        start = 1'b1;
        k = cyc;
        push_frame(base, k, ps, plen);
        check("idle_busy", busy, 0);
        @(posedge clock); #1;
        start = 1'b0;
        base_addr = 16'hDEAD;
        check("start_busy", busy, 1);
        check("first_rd_en", mem_rd_en, 1);
        check("first_addr", mem_addr, base);
        if (repulse) begin
            while (cyc < k + 5) begin @(posedge clock); #1; end
            start = 1'b1;
            base_addr = 16'h5555;
            @(posedge clock); #1;
            start = 1'b0;
        end
        if (plen > 0) begin
            while (cyc < k + ps) begin @(posedge clock); #1; end
            pause = 1'b1;
            while (cyc < k + ps + plen) begin @(posedge clock); #1; end
            pause = 1'b0;
        end
        for (int t = 0; t < 200 && done_cnt == d0; t++) begin
            @(negedge clock); #1;
        end
        check("done_count", done_cnt - d0, 1);
        check("done_cycle", done_cyc, k + 27 + plen);
        check("pixels_left", exp_q.size(), 0);
        @(posedge clock); #1;
        check("busy_after_done", {busy, done}, 0);
        repeat (30) @(posedge clock);
        #1;
        check("single_done", done_cnt - d0, 1);
        check("idle_after_frame", busy, 0);
    endtask

    initial begin
        int unsigned k;
        int d0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs",
              {mem_rd_en, mem_addr, data_out, data_out_valid, row_last, frame_last, busy, done}, 0);
        reset = 1'b0;

        run_frame(16'h0100, 0, 0, 1'b0);
        run_frame(16'h0100, 8, 3, 1'b0);
        run_frame(16'hFFFE, 0, 0, 1'b0);
        run_frame(16'h0100, 0, 0, 1'b1);

        // Abort mid-frame, just after pixel 10 has been emitted.
        @(posedge clock); #1;
        d0 = done_cnt;
        base_addr = 16'h0100;
        start = 1'b1;
        k = cyc;
        push_frame(16'h0100, k, 0, 0);
        @(posedge clock); #1;
        start = 1'b0;
        while (cyc < k + 12) begin @(posedge clock); #1; end
        @(negedge clock); #1;
        reset = 1'b1;
        #1;
        check("abort_outputs",
              {mem_rd_en, mem_addr, data_out, data_out_valid, row_last, frame_last, busy, done}, 0);
        check("abort_pixels_seen", exp_q.size(), 14);
        exp_q.delete();
        repeat (30) @(posedge clock);
        #1;
        check("no_done_after_abort", done_cnt - d0, 0);
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("idle_after_abort", {busy, mem_rd_en, data_out_valid}, 0);
        run_frame(16'h0100, 0, 0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
